alu_mc: RTL and testbench

- Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU.
- Adds valid/ready handshakes on both sides, an iterative shift-add multiplier, an optional iterative divider, and a high-word result output.
- Sits in the execute stage.
- The pipeline controller stalls on in_ready/out_valid instead of assuming zero latency.

---
 rtl/alu_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready handshakes.
//
// Single-cycle ops (shifts, add/sub, logic, set-less-than) complete one cycle
// after accept. MULU runs an iterative shift-add multiplier; DIVU (only when
// the ALU_DIV_EN macro is defined) runs a restoring divider on the same
// counter and datapath registers. Both iterative ops complete WIDTH cycles
// after accept. Without ALU_DIV_EN, opcode 12 is handled as an illegal op.
//
// Ports:
//   CLK        clock
//   RST        synchronous reset, active-high
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE)
//   aluop      operation code
//   ra, rb     operands (shift amount = rb[log2(WIDTH)-1:0])
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   out        primary result (low product / quotient)
//   out_hi     high product / remainder, 0 for other ops
//   negative   out[WIDTH-1]
//   overflow   signed add/sub overflow, MULU high word non-zero,
//              DIVU by zero, illegal opcode
//   zero       out == 0
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   aluop,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             negative,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_SLL  = OPW'(0);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(1);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(7);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(8);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(9);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(10);
  localparam logic [OPW-1:0] OP_MULU = OPW'(11);
`ifdef ALU_DIV_EN
  localparam logic [OPW-1:0] OP_DIVU = OPW'(12);
`endif

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_next;

  // Iterative datapath: hi_q/lo_q hold {partial product, multiplier} for
  // MULU and {remainder, dividend/quotient} for DIVU; opnd_q holds the
  // multiplicand or divisor.
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [SW-1:0]    cnt_q;

  // Registered result and flags.
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             neg_q, ovf_q, zero_q;

  // Single-cycle decode.
  logic [WIDTH-1:0] sc_out, add_res, sub_res;
  logic             sc_ovf, is_iter;
  logic [SW-1:0]    shamt;

  // One iteration step.
  logic [WIDTH-1:0] st_hi_in, st_lo_in, st_opnd;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   mul_sum;
  logic             fin_ovf;

`ifdef ALU_DIV_EN
  logic             is_div, div_q, st_div;
  logic [WIDTH:0]   div_shift, div_diff;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = res_q;
  assign out_hi    = res_hi_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  assign shamt   = rb[SW-1:0];
  assign add_res = ra + rb;
  assign sub_res = ra - rb;

  always_comb begin
    sc_out  = '0;
    sc_ovf  = 1'b0;
    is_iter = 1'b0;
`ifdef ALU_DIV_EN
    is_div  = 1'b0;
`endif
    case (aluop)
      OP_SLL:  sc_out = ra << shamt;
      OP_SRL:  sc_out = ra >> shamt;
      OP_SRA:  sc_out = $signed(ra) >>> shamt;
      OP_ADD: begin
        sc_out = add_res;
        sc_ovf = (ra[WIDTH-1] == rb[WIDTH-1]) && (add_res[WIDTH-1] != ra[WIDTH-1]);
      end
      OP_SUB: begin
        sc_out = sub_res;
        sc_ovf = (ra[WIDTH-1] != rb[WIDTH-1]) && (sub_res[WIDTH-1] != ra[WIDTH-1]);
      end
      OP_AND:  sc_out = ra & rb;
      OP_OR:   sc_out = ra | rb;
      OP_XOR:  sc_out = ra ^ rb;
      OP_NOR:  sc_out = ~(ra | rb);
      OP_SLT:  sc_out = WIDTH'($signed(ra) < $signed(rb));
      OP_SLTU: sc_out = WIDTH'(ra < rb);
      OP_MULU: is_iter = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIVU: begin
        is_iter = 1'b1;
        is_div  = 1'b1;
      end
`endif
      // Illegal opcode: out=0, overflow=1 (zero follows from out).
      default: sc_ovf = 1'b1;
    endcase
  end

  // The first iteration step is applied on the accept edge straight from the
  // input operands, so the remaining WIDTH-1 steps in BUSY land the result
  // exactly WIDTH cycles after accept.
  always_comb begin
    if (state == IDLE) begin
      st_hi_in = '0;
      st_lo_in = ra;
      st_opnd  = rb;
    end else begin
      st_hi_in = hi_q;
      st_lo_in = lo_q;
      st_opnd  = opnd_q;
    end

    // Shift-add: conditionally add multiplicand to the high half, then shift
    // the whole {carry, hi, lo} right by one; multiplier bits leave from lo.
    mul_sum = {1'b0, st_hi_in} + (st_lo_in[0] ? {1'b0, st_opnd} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], st_lo_in[WIDTH-1:1]};
    fin_ovf = (step_hi != '0);

`ifdef ALU_DIV_EN
    st_div = (state == IDLE) ? is_div : div_q;
    // Restoring step: shift the next dividend bit into the remainder and try
    // to subtract; bit WIDTH of the difference is the borrow. A zero divisor
    // naturally yields quotient all-ones and remainder equal to the dividend.
    div_shift = {st_hi_in, st_lo_in[WIDTH-1]};
    div_diff  = div_shift - {1'b0, st_opnd};
    if (st_div) begin
      fin_ovf = (st_opnd == '0);
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {st_lo_in[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {st_lo_in[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = is_iter ? BUSY : DONE;
      BUSY: if (cnt_q == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              hi_q   <= step_hi;
              lo_q   <= step_lo;
              opnd_q <= rb;
              cnt_q  <= SW'(WIDTH - 2);
`ifdef ALU_DIV_EN
              div_q  <= is_div;
`endif
            end else begin
              res_q    <= sc_out;
              res_hi_q <= '0;
              neg_q    <= sc_out[WIDTH-1];
              ovf_q    <= sc_ovf;
              zero_q   <= (sc_out == '0);
            end
          end
        end
        BUSY: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            res_q    <= step_lo;
            res_hi_q <= step_hi;
            neg_q    <= step_lo[WIDTH-1];
            ovf_q    <= fin_ovf;
            zero_q   <= (step_lo == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32, OPW=4). Expected results come
// from a behavioural model pushed onto a scoreboard queue at issue time and
// popped when out_valid appears. Opcode 12 expectations follow ALU_DIV_EN.
module tb_alu_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [31:0] ra, rb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out, out_hi;
  logic        negative, overflow, zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] o;
    logic [31:0] hi;
    logic        n;
    logic        v;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_mc #(.WIDTH(32), .OPW(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .ra(ra), .rb(rb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi),
    .negative(negative), .overflow(overflow), .zero(zero)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    logic [4:0]  sh;
    sh    = b[4:0];
    e.o   = '0;
    e.hi  = '0;
    e.v   = 1'b0;
    e.lat = 1;
    case (op)
      4'd0:  e.o = a << sh;
      4'd1:  e.o = a >> sh;
      4'd2:  e.o = $signed(a) >>> sh;
      4'd3: begin e.o = a + b; e.v = (a[31] == b[31]) && (e.o[31] != a[31]); end
      4'd4: begin e.o = a - b; e.v = (a[31] != b[31]) && (e.o[31] != a[31]); end
      4'd5:  e.o = a & b;
      4'd6:  e.o = a | b;
      4'd7:  e.o = a ^ b;
      4'd8:  e.o = ~(a | b);
      4'd9:  e.o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: e.o = (a < b) ? 32'd1 : 32'd0;
      4'd11: begin
        p     = {32'd0, a} * {32'd0, b};
        e.o   = p[31:0];
        e.hi  = p[63:32];
        e.v   = (e.hi != 0);
        e.lat = 32;
      end
`ifdef ALU_DIV_EN
      4'd12: begin
        e.lat = 32;
        if (b == 0) begin
          e.o = 32'hFFFF_FFFF; e.hi = a; e.v = 1'b1;
        end else begin
          e.o = a / b; e.hi = a % b;
        end
      end
`endif
      default: e.v = 1'b1;
    endcase
    e.n = e.o[31];
    e.z = (e.o == 0);
    return e;
  endfunction

  // Drives one request; returns 1 ns after the accept edge with inputs
  // scrambled so any late sampling of operands shows up.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready op=%0d in_ready=%b want 1", op, in_ready);
    end
    in_valid = 1'b1;
    aluop    = op;
    ra       = a;
    rb       = b;
    sb.push_back(model(op, a, b));
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    aluop    = 4'($urandom);
    ra       = $urandom;
    rb       = $urandom;
  endtask

  // Waits for the result, checks latency and values, optionally holds
  // out_ready low for 'hold' cycles (presenting a competing request), then
  // releases and checks the return to IDLE.
  task automatic collect(input int hold, input string name);
    exp_t e;
    int   n;
    logic [31:0] o0;
    n = 1;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    e = sb.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout out_valid=%b want 1 within 100 cycles", name, out_valid);
      return;
    end
    total++;
    if (n != e.lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d", name, n, e.lat);
    end
    total++;
    if ({out, out_hi, negative, overflow, zero} !== {e.o, e.hi, e.n, e.v, e.z}) begin
      bad++;
      $display("FAIL %s_result out=%h hi=%h n=%b v=%b z=%b want out=%h hi=%h n=%b v=%b z=%b",
               name, out, out_hi, negative, overflow, zero, e.o, e.hi, e.n, e.v, e.z);
    end
    o0 = out;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      aluop    = 4'd3;
      ra       = 32'h0000_1111;
      rb       = 32'h0000_2222;
      @(posedge CLK);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== o0 || out_hi !== e.hi) begin
        bad++;
        $display("FAIL %s_hold cyc=%0d valid=%b ready=%b out=%h hi=%h want valid=1 ready=0 out=%h hi=%h",
                 name, i, out_valid, in_ready, out, out_hi, o0, e.hi);
      end
    end
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluop = '0; ra = '0; rb = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({in_ready, out_valid, out, out_hi, negative, overflow, zero} !== {1'b1, 1'b0, 64'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset_init ready=%b valid=%b out=%h hi=%h flags=%b%b%b want ready=1 valid=0 rest 0",
               in_ready, out_valid, out, out_hi, negative, overflow, zero);
    end
    @(negedge CLK);
    RST = 1'b0;
    // Reset in the middle of a multiply.
    send(4'd11, 32'hFFFF_FFFF, 32'd2);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if ({in_ready, out_valid, out, out_hi, negative, overflow, zero} !== {1'b1, 1'b0, 64'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset_busy ready=%b valid=%b out=%h hi=%h flags=%b%b%b want ready=1 valid=0 rest 0",
               in_ready, out_valid, out, out_hi, negative, overflow, zero);
    end
    sb.delete();
    // The discarded multiply must not complete later.
    repeat (40) @(posedge CLK);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_discard valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_add();
    send(4'd3, 32'h7FFF_FFFF, 32'd1);         collect(0, "add_ovf");
    send(4'd3, 32'hFFFF_FFFF, 32'd1);         collect(0, "add_wrap");
  endtask

  task automatic test_sub();
    send(4'd4, 32'd5, 32'd5);                 collect(0, "sub_zero");
    send(4'd4, 32'h8000_0000, 32'd1);         collect(0, "sub_ovf");
  endtask

  task automatic test_shift_logic();
    send(4'd0, 32'd1, 32'd33);                collect(0, "sll_mask");
    send(4'd1, 32'h8000_0000, 32'd31);        collect(0, "srl");
    send(4'd2, 32'h8000_0000, 32'd4);         collect(0, "sra");
    send(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00); collect(0, "and");
    send(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00); collect(0, "or");
    send(4'd7, 32'hF0F0_1234, 32'h0FF0_FF00); collect(0, "xor");
    send(4'd8, 32'hF0F0_1234, 32'h0FF0_FF00); collect(0, "nor");
    send(4'd10, 32'd1, 32'hFFFF_FFFF);        collect(0, "sltu");
  endtask

  task automatic test_mulu();
    send(4'd11, 32'hFFFF_FFFF, 32'd2);        collect(0, "mulu_ovf");
    send(4'd11, 32'h1234_5678, 32'h9ABC_DEF0); collect(0, "mulu_big");
    send(4'd11, 32'd0, 32'hFFFF_FFFF);        collect(0, "mulu_zero");
  endtask

  task automatic test_divu();
    send(4'd12, 32'd100, 32'd7);              collect(0, "divu");
    send(4'd12, 32'd100, 32'd0);              collect(0, "divu_by0");
    send(4'd12, 32'hFFFF_FFFF, 32'd1);        collect(0, "divu_one");
  endtask

  task automatic test_illegal();
    for (int op = 13; op < 16; op++) begin
      send(4'(op), 32'h1234_5678, 32'h1);
      collect(0, "illegal");
    end
  endtask

  task automatic test_backpressure();
    send(4'd9, 32'hFFFF_FFFF, 32'd1);
    collect(5, "bp_slt");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      send(op, a, b);
      collect(0, "b2b");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift_logic();
    test_mulu();
    test_divu();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
